// File: rtl/mips_mc_if.sv
// Shared memory port of the mips_mc core: one valid/ready channel carries
// instruction fetches, loads and stores.
interface mips_mc_if #(
    parameter int ADDR_W = 32
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_ready;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/mips_mc.sv
// Multi-cycle MIPS subset core with one stallable memory port, halt on fault.
// Optional performance counters (cyc_cnt, instret_cnt) under `MIPS_MC_PERF_EN.
module mips_mc #(
    parameter int          ADDR_W   = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         reset,
    mips_mc_if.master    bus,
    output logic [31:0]  pc_out,
    output logic         retire,
    output logic         halted
`ifdef MIPS_MC_PERF_EN
    ,
    output logic [31:0]  cyc_cnt,
    output logic [31:0]  instret_cnt
`endif
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] FN_BREAK = 6'h0D;

    state_t      state_r;
    state_t      state_nx_s;
    logic [31:0] pc_r;
    logic [31:0] ir_r;
    logic [31:0] a_r;
    logic [31:0] b_r;
    logic [31:0] tgt_r;
    logic [31:0] alu_r;
    logic [31:0] mdr_r;
    logic [31:0] rf_r [32];

    logic [5:0]  opcode_s;
    logic [5:0]  funct_s;
    logic [4:0]  rs_s;
    logic [4:0]  rt_s;
    logic [4:0]  rd_s;
    logic [31:0] imm_sext_s;
    logic [31:0] ea_s;
    logic [31:0] exec_res_s;
    logic [4:0]  wb_dst_s;
    logic [31:0] wb_data_s;
    logic        is_store_s;

    function automatic logic legal_instr(input logic [31:0] instr);
        logic ok;
        case (instr[31:26])
            OP_RTYPE: begin
                case (instr[5:0])
                    6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, FN_BREAK: ok = 1'b1;
                    default:                                       ok = 1'b0;
                endcase
            end
            OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW: ok = 1'b1;
            default:                             ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [31:0] alu_op(input logic [5:0] fn, input logic [31:0] a,
                                           input logic [31:0] b);
        logic [31:0] res;
        case (fn)
            6'h20:   res = a + b;
            6'h22:   res = a - b;
            6'h24:   res = a & b;
            6'h25:   res = a | b;
            6'h2A:   res = {31'd0, ($signed(a) < $signed(b))};
            default: res = 32'd0;
        endcase
        return res;
    endfunction

    assign opcode_s   = ir_r[31:26];
    assign funct_s    = ir_r[5:0];
    assign rs_s       = ir_r[25:21];
    assign rt_s       = ir_r[20:16];
    assign rd_s       = ir_r[15:11];
    assign imm_sext_s = {{16{ir_r[15]}}, ir_r[15:0]};
    assign ea_s       = a_r + imm_sext_s;
    assign is_store_s = (opcode_s == OP_SW);
    assign wb_dst_s   = (opcode_s == OP_RTYPE) ? rd_s : rt_s;
    assign wb_data_s  = (opcode_s == OP_LW) ? mdr_r : alu_r;

    // Memory request is gated by reset combinationally so an abandoned
    // transaction drops in the very cycle reset is raised.
    assign bus.mem_req   = !reset && ((state_r == S_FETCH) || (state_r == S_MEM));
    assign bus.mem_we    = !reset && (state_r == S_MEM) && is_store_s;
    assign bus.mem_addr  = (state_r == S_MEM) ? alu_r[ADDR_W-1:0] : pc_r[ADDR_W-1:0];
    assign bus.mem_wdata = b_r;
    assign pc_out        = pc_r;
    assign halted        = !reset && (state_r == S_HALT);

    // Execute-stage result selection.
    always_comb begin
        exec_res_s = ea_s;
        if (opcode_s == OP_RTYPE) begin
            exec_res_s = alu_op(funct_s, a_r, b_r);
        end else begin
            exec_res_s = ea_s;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= S_FETCH;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state and retire decode.
    always_comb begin
        state_nx_s = state_r;
        retire     = 1'b0;
        case (state_r)
            S_FETCH: begin
                if (bus.mem_ready) state_nx_s = S_DECODE;
                else               state_nx_s = S_FETCH;
            end
            S_DECODE: begin
                if (legal_instr(ir_r)) state_nx_s = S_EXEC;
                else                   state_nx_s = S_HALT;
            end
            S_EXEC: begin
                case (opcode_s)
                    OP_RTYPE: begin
                        if (funct_s == FN_BREAK) state_nx_s = S_HALT;
                        else                     state_nx_s = S_WB;
                    end
                    OP_ADDI: state_nx_s = S_WB;
                    OP_LW, OP_SW: begin
                        if (ea_s[1:0] != 2'b00) state_nx_s = S_HALT;
                        else                    state_nx_s = S_MEM;
                    end
                    OP_BEQ, OP_J: begin
                        state_nx_s = S_FETCH;
                        retire     = 1'b1;
                    end
                    default: state_nx_s = S_HALT;
                endcase
            end
            S_MEM: begin
                if (bus.mem_ready) begin
                    state_nx_s = is_store_s ? S_FETCH : S_WB;
                    retire     = is_store_s;
                end else begin
                    state_nx_s = S_MEM;
                end
            end
            S_WB: begin
                state_nx_s = S_FETCH;
                retire     = 1'b1;
            end
            S_HALT:  state_nx_s = S_HALT;
            default: state_nx_s = S_HALT;
        endcase
        if (reset) begin
            retire = 1'b0;
        end else begin
            retire = retire;
        end
    end

    // Datapath registers and register file.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_r  <= RESET_PC;
            ir_r  <= 32'd0;
            a_r   <= 32'd0;
            b_r   <= 32'd0;
            tgt_r <= 32'd0;
            alu_r <= 32'd0;
            mdr_r <= 32'd0;
            for (int i = 0; i < 32; i++) begin
                rf_r[i] <= 32'd0;
            end
        end else begin
            case (state_r)
                S_FETCH: begin
                    if (bus.mem_ready) begin
                        ir_r <= bus.mem_rdata;
                        pc_r <= pc_r + 32'd4;
                    end
                end
                S_DECODE: begin
                    a_r   <= (rs_s == 5'd0) ? 32'd0 : rf_r[rs_s];
                    b_r   <= (rt_s == 5'd0) ? 32'd0 : rf_r[rt_s];
                    tgt_r <= pc_r + {imm_sext_s[29:0], 2'b00};
                end
                S_EXEC: begin
                    alu_r <= exec_res_s;
                    if ((opcode_s == OP_BEQ) && (a_r == b_r)) begin
                        pc_r <= tgt_r;
                    end else if (opcode_s == OP_J) begin
                        pc_r <= {pc_r[31:28], ir_r[25:0], 2'b00};
                    end
                end
                S_MEM: begin
                    if (bus.mem_ready && !is_store_s) begin
                        mdr_r <= bus.mem_rdata;
                    end
                end
                S_WB: begin
                    if (wb_dst_s != 5'd0) begin
                        rf_r[wb_dst_s] <= wb_data_s;
                    end
                end
                default: begin
                    pc_r <= pc_r;
                end
            endcase
        end
    end

`ifdef MIPS_MC_PERF_EN
    // Cycle and retired-instruction counters; both wrap naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            cyc_cnt     <= 32'd0;
            instret_cnt <= 32'd0;
        end else begin
            if (state_r != S_HALT) cyc_cnt <= cyc_cnt + 32'd1;
            else                   cyc_cnt <= cyc_cnt;
            if (retire) instret_cnt <= instret_cnt + 32'd1;
            else        instret_cnt <= instret_cnt;
        end
    end
`endif

endmodule

// File: tb/tb_mips_mc.sv
// Directed testbench for mips_mc: word memory model with programmable stalls,
// hand-encoded programs and hand-computed cycle counts and results.
module tb_mips_mc;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_out;
    logic        retire;
    logic        halted;
`ifdef MIPS_MC_PERF_EN
    logic [31:0] cyc_cnt;
    logic [31:0] instret_cnt;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mips_mc_if #(.ADDR_W(32)) bus ();

    mips_mc #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .pc_out      (pc_out),
        .retire      (retire),
        .halted      (halted)
`ifdef MIPS_MC_PERF_EN
        ,
        .cyc_cnt     (cyc_cnt),
        .instret_cnt (instret_cnt)
`endif
    );

    // Memory model: 256 words, stall_n wait cycles before every ready.
    logic [31:0] mem [256];
    logic [31:0] img [256];
    logic        load_en = 1'b0;
    int          stall_n = 0;
    int          stall_cnt = 0;

    always_comb begin
        bus.mem_ready = bus.mem_req && (stall_cnt >= stall_n);
        bus.mem_rdata = mem[bus.mem_addr[9:2]];
    end

    always @(posedge clk) begin
        if (load_en) begin
            mem <= img;
            stall_cnt <= 0;
        end else if (bus.mem_req && bus.mem_ready) begin
            if (bus.mem_we) mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
            stall_cnt <= 0;
        end else if (bus.mem_req) begin
            stall_cnt <= stall_cnt + 1;
        end else begin
            stall_cnt <= 0;
        end
    end

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] enc_j(input logic [25:0] t);
        return {6'h02, t};
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_img();
        for (int i = 0; i < 256; i++) img[i] = 32'd0;
    endtask

    // Hold reset two cycles while the image is copied into memory; returns with reset still high.
    task automatic do_reset();
        reset   = 1'b1;
        load_en = 1'b1;
        step();
        step();
        load_en = 1'b0;
    endtask

    // Release reset; returns observing cycle 1.
    task automatic release_rst();
        reset = 1'b0;
        #1;
    endtask

    task automatic wait_retire(input int budget, output int n);
        n = 0;
        while (retire !== 1'b1 && n < budget) begin
            step();
            n++;
        end
        if (retire !== 1'b1) check_val("retire_timeout", 32'(retire), 32'd1);
    endtask

    // From a fetch cycle, count cycles up to and including the retire cycle.
    task automatic measure(input bit chk_st, input logic [31:0] ea, input logic [31:0] wd,
                           output int lat);
        lat = 1;
        while (retire !== 1'b1 && lat < 40) begin
            if (chk_st && bus.mem_req && bus.mem_we) begin
                check_val("st_addr_hold", bus.mem_addr, ea);
                check_val("st_wdata_hold", bus.mem_wdata, wd);
            end
            step();
            lat++;
        end
    endtask

    task automatic wait_halt(input int budget);
        int n = 0;
        while (halted !== 1'b1 && n < budget) begin
            step();
            n++;
        end
        check_val("halt_reached", 32'(halted), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int lat;
        int rc;
        reset = 1'b1;

        // ---------------- ALU sequence and control flow ----------------
        clear_img();
        img[0]  = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
        img[1]  = enc_i(6'h08, 5'd0, 5'd2, 16'hFFFD);
        img[2]  = enc_r(5'd1, 5'd2, 5'd3, 6'h20);
        img[3]  = enc_r(5'd2, 5'd1, 5'd4, 6'h2A);
        img[4]  = enc_i(6'h04, 5'd1, 5'd1, 16'd2);
        img[7]  = enc_i(6'h2B, 5'd0, 5'd3, 16'h0080);
        img[8]  = enc_i(6'h2B, 5'd0, 5'd4, 16'h0084);
        img[9]  = enc_i(6'h04, 5'd1, 5'd2, 16'd5);
        img[10] = enc_j(26'h40);
        img[64] = enc_r(5'd0, 5'd0, 5'd0, 6'h0D);
        stall_n = 0;
        do_reset();
        check_val("rst_mem_req", 32'(bus.mem_req), 32'd0);
        check_val("rst_mem_we", 32'(bus.mem_we), 32'd0);
        check_val("rst_halted", 32'(halted), 32'd0);
        check_val("rst_retire", 32'(retire), 32'd0);
        release_rst();
        check_val("c1_mem_req", 32'(bus.mem_req), 32'd1);
        check_val("c1_mem_addr", bus.mem_addr, 32'h0);
        check_val("c1_retire", 32'(retire), 32'd0);
        for (int c = 2; c <= 16; c++) begin
            step();
            if (c == 2) check_val("c2_pc_out", pc_out, 32'h4);
            check_val($sformatf("retire_c%0d", c), 32'(retire), 32'((c % 4) == 0));
        end
        step();
        check_val("fetch_beq", bus.mem_addr, 32'h10);
        wait_retire(8, n);
        check_val("beq_lat", 32'(n), 32'd2);
        step();
        check_val("beq_taken_fetch", bus.mem_addr, 32'h1C);
        check_val("beq_taken_pc", pc_out, 32'h1C);
        wait_retire(8, n);
        check_val("sw_lat", 32'(n), 32'd3);
        step();
        check_val("fetch_sw2", bus.mem_addr, 32'h20);
        wait_retire(8, n);
        step();
        check_val("fetch_beq_nt", bus.mem_addr, 32'h24);
        wait_retire(8, n);
        step();
        check_val("beq_nt_fetch", bus.mem_addr, 32'h28);
        wait_retire(8, n);
        check_val("j_lat", 32'(n), 32'd2);
        step();
        check_val("j_fetch", bus.mem_addr, 32'h100);
        step();
        step();
        step();
        check_val("break_halted", 32'(halted), 32'd1);
        check_val("break_mem_req", 32'(bus.mem_req), 32'd0);
        check_val("add_result", mem[32], 32'd2);
        check_val("slt_result", mem[33], 32'd1);

        // ---------------- memory access with stalls ----------------
        clear_img();
        img[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
        img[1] = enc_i(6'h2B, 5'd0, 5'd1, 16'h0048);
        img[2] = enc_i(6'h23, 5'd0, 5'd5, 16'h0048);
        img[3] = enc_i(6'h2B, 5'd0, 5'd5, 16'h0088);
        img[4] = enc_r(5'd0, 5'd0, 5'd0, 6'h0D);
        stall_n = 3;
        do_reset();
        release_rst();
        wait_retire(20, n);
        check_val("addi_stall_lat", 32'(n), 32'd6);
        step();
        measure(1'b1, 32'h48, 32'd5, lat);
        check_val("sw_stall_lat", 32'(lat), 32'd10);
        step();
        measure(1'b0, 32'h0, 32'h0, lat);
        check_val("lw_stall_lat", 32'(lat), 32'd11);
        wait_halt(40);
        check_val("sw_mem", mem[18], 32'd5);
        check_val("lw_r5", mem[34], 32'd5);

        // ---------------- halts ----------------
        clear_img();
        img[0] = enc_i(6'h23, 5'd0, 5'd1, 16'd2);
        stall_n = 0;
        do_reset();
        release_rst();
        for (int c = 2; c <= 6; c++) begin
            step();
            check_val($sformatf("misal_req_c%0d", c), 32'(bus.mem_req), 32'd0);
            check_val($sformatf("misal_ret_c%0d", c), 32'(retire), 32'd0);
        end
        check_val("misal_halted", 32'(halted), 32'd1);
        clear_img();
        img[0] = 32'hFC00_0000;
        do_reset();
        check_val("halt_rst_halted", 32'(halted), 32'd0);
        check_val("halt_rst_req", 32'(bus.mem_req), 32'd0);
        release_rst();
        check_val("restart_req", 32'(bus.mem_req), 32'd1);
        check_val("restart_addr", bus.mem_addr, 32'h0);
        step();
        step();
        check_val("op3f_halted", 32'(halted), 32'd1);
        check_val("op3f_req", 32'(bus.mem_req), 32'd0);

        // ---------------- reset during MEM stall, then counters ----------------
        clear_img();
        img[0] = enc_i(6'h23, 5'd0, 5'd1, 16'h0040);
        stall_n = 3;
        do_reset();
        release_rst();
        n = 0;
        while (!(bus.mem_req && bus.mem_addr == 32'h40) && n < 30) begin
            step();
            n++;
        end
        check_val("mem_phase_addr", bus.mem_addr, 32'h40);
        step();
        reset = 1'b1;
        #1;
        check_val("midmem_rst_req", 32'(bus.mem_req), 32'd0);
        check_val("midmem_rst_we", 32'(bus.mem_we), 32'd0);
        clear_img();
        img[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd1);
        img[1] = enc_i(6'h08, 5'd0, 5'd2, 16'd2);
        img[2] = enc_i(6'h08, 5'd0, 5'd3, 16'd3);
        stall_n = 0;
        do_reset();
        release_rst();
        rc = 0;
        for (int c = 1; c <= 10; c++) begin
            if (retire === 1'b1) rc++;
            step();
        end
        check_val("retires_10cyc", 32'(rc), 32'd2);
`ifdef MIPS_MC_PERF_EN
        check_val("cyc_cnt", cyc_cnt, 32'd10);
        check_val("instret_cnt", instret_cnt, 32'd2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
